// File: rtl/tipi_link_pkg.sv
// Shared encodings for the TIPI link sequencer: request opcodes, FSM states, bits per transfer.
package tipi_link_pkg;

  localparam int TIPI_LINK_BITS = 8;

  // req_op[1] selects the TI->RPi direction (read), req_op[0] the data register
  localparam logic [1:0] OP_WR_RC = 2'b00;
  localparam logic [1:0] OP_WR_RD = 2'b01;
  localparam logic [1:0] OP_RD_TC = 2'b10;
  localparam logic [1:0] OP_RD_TD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_LATCH,
    ST_PARCHK,
    ST_DONE
  } tipi_link_state_e;

  function automatic logic op_is_read(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/tipi_link_tick.sv
// Half-period timer: reloads CLK_DIV-1 on restart_i, counts down, tick_o high while at zero.
module tipi_link_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic tick_o
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = RELOAD;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == 8'd0);

endmodule

// File: rtl/tipi_link_seq.sv
// TIPI link-side sequencer: serialises one host byte operation onto the r_* link.
// Optional write parity check after latch is enabled by defining TIPI_LINK_PARITY_EN.
module tipi_link_seq
  import tipi_link_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int BITS    = TIPI_LINK_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [7:0]       req_data,
  output logic             rsp_valid,
  output logic [7:0]       rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic             r_clk,
  output logic             r_cd,
  output logic             r_rt,
  output logic             r_le,
  output logic             r_dout,
  input  logic             r_din,
  input  logic             r_reset,
  output tipi_link_state_e dbg_state_o
);

  localparam int BW = $clog2(BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(BITS - 1);

  // Handshake: a request transfers on a clk edge where req_valid & req_ready;
  // req_ready is high only in IDLE with r_reset low, and req_* need not be held afterwards.
  tipi_link_state_e state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       shift_q, shift_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             err_q, err_d;
  logic             par_hi_q, par_hi_d;
  logic             restart;
  logic             tick;

  tipi_link_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .restart_i (restart),
    .tick_o    (tick)
  );

  assign req_ready = (state_q == ST_IDLE) && !r_reset;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    err_d    = err_q;
    par_hi_d = par_hi_q;
    restart  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          state_d = ST_SETUP;
          op_d    = req_op;
          data_d  = req_data;
          shift_d = 8'h00;
          bit_d   = '0;
          err_d   = 1'b0;
          restart = 1'b1;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = op_is_read(op_q) ? ST_LOAD : ST_CLK_LO;
          restart = 1'b1;
        end
      end
      ST_LOAD: begin
        if (tick) begin
          state_d = ST_CLK_LO;
          restart = 1'b1;
        end
      end
      ST_CLK_LO: begin
        if (tick) begin
          state_d = ST_CLK_HI;
          restart = 1'b1;
        end
      end
      ST_CLK_HI: begin
        if (tick) begin
          // TIPI has presented bit 7-k since rise k+1, so it is stable here
          if (op_is_read(op_q)) begin
            shift_d[LAST_BIT - bit_q] = r_din;
          end
          bit_d   = bit_q + BW'(1);
          restart = 1'b1;
          if (bit_q == LAST_BIT) begin
            state_d = op_is_read(op_q) ? ST_DONE : ST_LATCH;
          end else begin
            state_d = ST_CLK_LO;
          end
        end
      end
      ST_LATCH: begin
        if (tick) begin
          restart = 1'b1;
`ifdef TIPI_LINK_PARITY_EN
          state_d  = ST_PARCHK;
          par_hi_d = 1'b0;
`else
          state_d  = ST_DONE;
`endif
        end
      end
`ifdef TIPI_LINK_PARITY_EN
      ST_PARCHK: begin
        if (tick) begin
          restart = 1'b1;
          if (!par_hi_q) begin
            par_hi_d = 1'b1;
          end else begin
            par_hi_d = 1'b0;
            err_d    = (r_din != ^data_q);
            state_d  = ST_DONE;
          end
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Abort is skipped in DONE so one operation never yields two responses
    if (r_reset && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      state_d  = ST_DONE;
      err_d    = 1'b1;
      par_hi_d = 1'b0;
      restart  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= 2'b00;
      data_q   <= 8'h00;
      shift_q  <= 8'h00;
      bit_q    <= '0;
      err_q    <= 1'b0;
      par_hi_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      err_q    <= err_d;
      par_hi_q <= par_hi_d;
    end
  end

  always_comb begin
    r_clk  = (state_q == ST_CLK_HI) || ((state_q == ST_PARCHK) && par_hi_q);
    r_le   = (state_q == ST_LOAD) || (state_q == ST_LATCH) || (state_q == ST_PARCHK);
    r_dout = 1'b0;
    if (((state_q == ST_CLK_LO) || (state_q == ST_CLK_HI)) && !op_is_read(op_q)) begin
      r_dout = data_q[LAST_BIT - bit_q];
    end
    rsp_valid = (state_q == ST_DONE);
    rsp_err   = (state_q == ST_DONE) && err_q;
    rsp_data  = 8'h00;
    if ((state_q == ST_DONE) && op_is_read(op_q) && !err_q) begin
      rsp_data = shift_q;
    end
  end

  assign r_rt        = op_q[1];
  assign r_cd        = op_q[0];
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule
